accuml_dump_ctrl: RTL and testbench
===================================

Name: accuml_dump_ctrl

Overview:
- Integrate-and-dump controller that sits directly upstream of the `accuml` fixed-point accumulator.
- Accepts a valid/ready sample stream and converts it into the `clr`/`add_sub`/`D` drive for `accuml`.
- Reads `accuml`'s `Q` back after each window of N samples and emits one dump result per window.
- Used for decimating integrators and phase/energy sums in the FixedPoint math group.

Parameters:
- `WIDTH`, 16, sample width; matches the `accuml` `WIDTH`. The dump result is `WIDTH+1` bits.
- `CNT_WIDTH`, 8, width of the window-length input and the internal sample counter.
- `ACC_LAT`, 1, cycles from a sample driven on `acc_D` to the updated sum being visible on `acc_Q` (≥1).

Ports:
- `clock`, input, 1, single system clock; all logic on the rising edge.
- `reset`, input, 1, synchronous, active-high reset.
- `in_valid`, input, 1, input sample valid.
- `in_ready`, output, 1, controller can accept a sample this cycle.
- `in_data`, input, `WIDTH`, sample magnitude.
- `in_sub`, input, 1, per-sample operation: 0 = add, 1 = subtract.
- `dump_len`, input, `CNT_WIDTH`, samples per window N; sampled on the first accepted sample of each window.
- `acc_clr`, output, 1, to `accuml` `clr`.
- `acc_add_sub`, output, 1, to `accuml` `add_sub`.
- `acc_D`, output, `WIDTH`, to `accuml` `D`.
- `acc_Q`, input, `WIDTH+1`, from `accuml` `Q`.
- `out_valid`, output, 1, one-cycle pulse, dump result valid.
- `out_data`, output, `WIDTH+1`, dump result (window sum).

Behaviour:
- **Accumulator contract:**
  - A cycle with `clr=1` starts a new sum with that cycle's `±D`.
  - A cycle with `clr=0` adds or subtracts `D`.
  - `D=0` holds the sum.
- **Acceptance:** a sample is accepted when `in_valid && in_ready`.
- **Registered outputs:** `acc_*`, `out_*` and `in_ready` are all registered.
- **Reset:** state IDLE, counter 0, `in_ready=1`, `acc_clr=0`, `acc_add_sub=0`, `acc_D=0`, `out_valid=0`, `out_data=0`. Reset mid-window discards the window with no output; reset has priority over all other events.
- **Idle drive:** in every cycle without an accepted sample, `acc_D=0`, `acc_add_sub=0`, `acc_clr=0`.
- **Sample drive:** accepted sample in cycle k produces `acc_D=in_data`, `acc_add_sub=in_sub` in cycle k+1.
- **States:**
  - IDLE: `in_ready=1`.
    - On acceptance, latch `N=dump_len`; `dump_len=0` is treated as 1.
    - Drive `acc_clr=1` with this sample in the next cycle.
    - Set count=1, then go to DRAIN if N==1, else ACCUM.
  - ACCUM: `in_ready=1`.
    - Each acceptance drives the sample with `acc_clr=0` and increments count.
    - The acceptance with count+1==N goes to DRAIN.
    - Cycles without `in_valid` only insert zero-drive cycles; the sum is unchanged.
  - DRAIN: `in_ready=0`.
    - If the last sample is on `acc_D` in cycle L, capture `out_data<=acc_Q` at the end of cycle L+`ACC_LAT`.
    - `out_valid=1` in cycle L+`ACC_LAT`+1, then return to IDLE.
    - `in_ready` is 0 from cycle k+1 (k = last acceptance) through the `out_valid` cycle inclusive, and returns to 1 the cycle after.
- **Output hold:** `out_data` holds its value until the next dump. `out_valid` is never asserted for more than 1 cycle.
- **Width rules:**
  - `out_data` is `acc_Q` verbatim, `WIDTH+1` bits, with no truncation.
  - The controller does no arithmetic on data; overflow behaviour is `accuml`'s.
  - The counter is `CNT_WIDTH` bits; N max = 2^`CNT_WIDTH`−1.
- **`dump_len` timing:** changes to `dump_len` mid-window are ignored until the next IDLE acceptance.

Optional Feature:
- Macro: `ACCUML_DUMP_DROP_CNT_EN`.
- When defined, adds output `drop_cnt [15:0]`:
  - Increments in each cycle with `in_valid=1 && in_ready=0`.
  - Saturates at 16'hFFFF; cleared by reset only.
- When undefined, the port and logic are absent and behaviour is otherwise identical.

Test Plan:
- **Constant add:** `ACC_LAT=1`, `accuml` model attached; N=4, four back-to-back samples of 10000 with add → one `out_valid` pulse, `out_data`=40000 (17'h09C40); `acc_clr` high only with the first sample.
- **Mixed ops:** N=4, samples +5000, −2000, −2000, +1000 → `out_data`=2000; next window N=2, +300, +300 → 600, proving `clr` restarts the sum.
- **Single-sample window:** N=1 (and separately `dump_len`=0), sample 123 accepted at cycle k → `out_valid` at cycle k+3, `out_data`=123, IDLE after.
- **Bubbles:** N=3 with `in_valid` gaps of 0, 2 and 5 cycles between samples of 7 each → `out_data`=21; `acc_D`=0 during every gap.
- **Backpressure:**
  - Stimulus: `in_valid` held high continuously with `in_data`=1, N=2, `ACC_LAT`=1.
  - Required: `in_ready` low exactly 3 cycles after each window's second acceptance; every `out_data`=2.
  - With `ACCUML_DUMP_DROP_CNT_EN`: `drop_cnt` increments by 3 per window.
- **Reset mid-window:** N=8, reset asserted for 1 cycle after 5 samples → no `out_valid`, all outputs 0 next cycle; a following N=2 window of 10+10 → `out_data`=20.

Source files
------------

// File: rtl/accuml_dump_ctrl.sv
// Integrate-and-dump front end for the accuml accumulator: windows of N samples, one dump each.
// Optional ACCUML_DUMP_DROP_CNT_EN adds a saturating count of cycles stalled by backpressure.
module accuml_dump_ctrl #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned ACC_LAT   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sub,
  input  logic [CNT_WIDTH-1:0] dump_len,
  output logic                 acc_clr,
  output logic                 acc_add_sub,
  output logic [WIDTH-1:0]     acc_D,
  input  logic [WIDTH:0]       acc_Q,
  output logic                 out_valid,
`ifdef ACCUML_DUMP_DROP_CNT_EN
  output logic [15:0]          drop_cnt,
`endif
  output logic [WIDTH:0]       out_data
);

  localparam int unsigned LatW = $clog2(ACC_LAT + 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] len_q;
  logic [LatW-1:0]      lat_q;
  logic                 accept;
  logic [CNT_WIDTH-1:0] len_eff;

  assign accept  = in_valid && in_ready;
  // A zero window length behaves as a single-sample window.
  assign len_eff = (dump_len == '0) ? CNT_WIDTH'(1) : dump_len;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      lat_q       <= '0;
      in_ready    <= 1'b1;
      acc_clr     <= 1'b0;
      acc_add_sub <= 1'b0;
      acc_D       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      // Zero drive holds the accumulator sum in every cycle without a sample.
      acc_clr     <= 1'b0;
      acc_add_sub <= 1'b0;
      acc_D       <= '0;
      out_valid   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            acc_clr     <= 1'b1;
            acc_add_sub <= in_sub;
            acc_D       <= in_data;
            len_q       <= len_eff;
            cnt_q       <= CNT_WIDTH'(1);
            lat_q       <= '0;
            if (len_eff == CNT_WIDTH'(1)) begin
              state_q  <= StDrain;
              in_ready <= 1'b0;
            end else begin
              state_q <= StAccum;
            end
          end
        end
        StAccum: begin
          if (accept) begin
            acc_add_sub <= in_sub;
            acc_D       <= in_data;
            cnt_q       <= cnt_q + CNT_WIDTH'(1);
            lat_q       <= '0;
            if (cnt_q + CNT_WIDTH'(1) == len_q) begin
              state_q  <= StDrain;
              in_ready <= 1'b0;
            end
          end
        end
        StDrain: begin
          // Wait ACC_LAT cycles after the last sample leaves, capture, then pulse.
          if (out_valid) begin
            state_q  <= StIdle;
            in_ready <= 1'b1;
            cnt_q    <= '0;
          end else if (lat_q == LatW'(ACC_LAT)) begin
            out_data  <= acc_Q;
            out_valid <= 1'b1;
          end else begin
            lat_q <= lat_q + LatW'(1);
          end
        end
        default: begin
          state_q  <= StIdle;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef ACCUML_DUMP_DROP_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (in_valid && !in_ready && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_accuml_dump_ctrl.sv
// Randomized and directed bench for accuml_dump_ctrl with an attached accuml model and a
// window-level reference model predicting every output cycle by cycle.
module tb_accuml_dump_ctrl;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned CNT_WIDTH = 8;
  localparam int unsigned ACC_LAT   = 1;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 in_sub;
  logic [CNT_WIDTH-1:0] dump_len;
  logic                 acc_clr;
  logic                 acc_add_sub;
  logic [WIDTH-1:0]     acc_D;
  logic [WIDTH:0]       acc_Q;
  logic                 out_valid;
  logic [WIDTH:0]       out_data;
`ifdef ACCUML_DUMP_DROP_CNT_EN
  logic [15:0]          drop_cnt;
`endif

  accuml_dump_ctrl #(
    .WIDTH    (WIDTH),
    .CNT_WIDTH(CNT_WIDTH),
    .ACC_LAT  (ACC_LAT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sub     (in_sub),
    .dump_len   (dump_len),
    .acc_clr    (acc_clr),
    .acc_add_sub(acc_add_sub),
    .acc_D      (acc_D),
    .acc_Q      (acc_Q),
    .out_valid  (out_valid),
`ifdef ACCUML_DUMP_DROP_CNT_EN
    .drop_cnt   (drop_cnt),
`endif
    .out_data   (out_data)
  );

  always #5 clock = ~clock;

  // accuml behaviour: one-cycle latency, clr restarts the sum with +-D.
  logic [WIDTH:0] acc_q_m;
  assign acc_Q = acc_q_m;
  always @(posedge clock) begin
    if (reset) acc_q_m <= '0;
    else if (acc_clr) acc_q_m <= acc_add_sub ? (17'd0 - {1'b0, acc_D}) : {1'b0, acc_D};
    else acc_q_m <= acc_add_sub ? (acc_q_m - {1'b0, acc_D}) : (acc_q_m + {1'b0, acc_D});
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle time %0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  int cyc = 0;
  bit chk_en = 0;
  int busy_until = 0;
  int dump_cycle = -1;
  int dump_val = 0;
  int exp_out = 0;
  int exp_d = 0, exp_sub = 0, exp_clr = 0;
  int exp_drop = 0;
  int win_len = 0, win_cnt = 0, win_sum = 0;
  int last_dump = 0;
  int n_dumps = 0;

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic s,
                      input logic [CNT_WIDTH-1:0] len, input logic r);
    bit ready;
    in_valid = v;
    in_data  = d;
    in_sub   = s;
    dump_len = len;
    reset    = r;
    @(negedge clock);
    if (chk_en) begin
      if (cyc == dump_cycle) exp_out = dump_val;
      check("in_ready", 32'(in_ready), 32'(cyc > busy_until));
      check("acc_D", 32'(acc_D), exp_d);
      check("acc_add_sub", 32'(acc_add_sub), exp_sub);
      check("acc_clr", 32'(acc_clr), exp_clr);
      check("out_valid", 32'(out_valid), 32'(cyc == dump_cycle));
      check("out_data", 32'(out_data), exp_out);
`ifdef ACCUML_DUMP_DROP_CNT_EN
      check("drop_cnt", 32'(drop_cnt), exp_drop);
`endif
    end
    if (out_valid === 1'b1) begin
      last_dump = int'(out_data);
      n_dumps++;
    end
    exp_d = 0;
    exp_sub = 0;
    exp_clr = 0;
    if (r) begin
      win_cnt = 0;
      dump_cycle = -1;
      busy_until = cyc;
      exp_out = 0;
      exp_drop = 0;
      chk_en = 1;
    end else begin
      ready = (cyc > busy_until);
      if (v && !ready && exp_drop < 65535) exp_drop++;
      if (v && ready) begin
        if (win_cnt == 0) begin
          win_len = (len == 0) ? 1 : int'(len);
          win_sum = 0;
          exp_clr = 1;
        end
        exp_d = int'(d);
        exp_sub = int'(s);
        win_sum = s ? win_sum - int'(d) : win_sum + int'(d);
        win_cnt++;
        if (win_cnt == win_len) begin
          dump_cycle = cyc + int'(ACC_LAT) + 2;
          dump_val = win_sum & 32'h1FFFF;
          busy_until = dump_cycle;
          win_cnt = 0;
        end
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic s, input logic [CNT_WIDTH-1:0] len);
    step(1'b1, d, s, len, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 1'($urandom), 8'($urandom), 1'b0);
  endtask

  int dumps_before;

  initial begin
    in_valid = 0; in_data = 0; in_sub = 0; dump_len = 0; reset = 1;
    @(posedge clock);
    #1;
    step(1'b0, 16'd0, 1'b0, 8'd0, 1'b1);
    step(1'b0, 16'd0, 1'b0, 8'd0, 1'b1);
    idle(2);

    // Constant add.
    dumps_before = n_dumps;
    for (int i = 0; i < 4; i++) send(16'd10000, 1'b0, 8'd4);
    idle(4);
    check("const_add_sum", 32'(last_dump), 32'h09C40);
    check("const_add_pulses", 32'(n_dumps - dumps_before), 32'd1);

    // Mixed ops, then a fresh window proving clr restarts.
    send(16'd5000, 1'b0, 8'd4);
    send(16'd2000, 1'b1, 8'd4);
    send(16'd2000, 1'b1, 8'd4);
    send(16'd1000, 1'b0, 8'd4);
    idle(4);
    check("mixed_sum", 32'(last_dump), 32'd2000);
    send(16'd300, 1'b0, 8'd2);
    send(16'd300, 1'b0, 8'd2);
    idle(4);
    check("restart_sum", 32'(last_dump), 32'd600);

    // Single-sample windows, N=1 and dump_len=0.
    send(16'd123, 1'b0, 8'd1);
    idle(4);
    check("n1_sum", 32'(last_dump), 32'd123);
    send(16'd77, 1'b0, 8'd0);
    idle(4);
    check("len0_sum", 32'(last_dump), 32'd77);

    // Bubbles between samples; dump_len changes mid-window are ignored.
    send(16'd7, 1'b0, 8'd3);
    send(16'd7, 1'b0, 8'd9);
    idle(2);
    send(16'd7, 1'b0, 8'd1);
    idle(4);
    check("bubble_sum_a", 32'(last_dump), 32'd21);
    send(16'd7, 1'b0, 8'd3);
    idle(5);
    send(16'd7, 1'b0, 8'd3);
    send(16'd7, 1'b0, 8'd3);
    idle(4);
    check("bubble_sum_b", 32'(last_dump), 32'd21);

    // Continuous valid under backpressure.
    dumps_before = n_dumps;
    for (int i = 0; i < 15; i++) send(16'd1, 1'b0, 8'd2);
    idle(4);
    check("bp_sum", 32'(last_dump), 32'd2);
    check("bp_pulses", 32'(n_dumps - dumps_before), 32'd3);

    // Reset mid-window discards it.
    for (int i = 0; i < 5; i++) send(16'd100, 1'b0, 8'd8);
    dumps_before = n_dumps;
    step(1'b0, 16'd0, 1'b0, 8'd8, 1'b1);
    idle(6);
    check("rst_no_dump", 32'(n_dumps - dumps_before), 32'd0);
    send(16'd10, 1'b0, 8'd2);
    send(16'd10, 1'b0, 8'd2);
    idle(4);
    check("post_rst_sum", 32'(last_dump), 32'd20);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [CNT_WIDTH-1:0] len;
      len = ($urandom_range(15) == 0) ? 8'($urandom) : 8'($urandom_range(5));
      step(1'($urandom_range(3) != 0), 16'($urandom), 1'($urandom),
           len, 1'($urandom_range(599) == 0));
    end
    idle(300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
